// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: one shared edge/centre-aligned timebase, per-channel duty,
// polarity and complementary outputs with dead-time; duty/period/dead-time double-buffered.
module pwm_multichannel #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 8,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 align,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic                 period_wen,
  input  logic [CNT_WIDTH-1:0] duty_in,
  input  logic [SEL_W-1:0]     duty_sel,
  input  logic                 duty_wen,
  input  logic [DT_WIDTH-1:0]  deadtime_in,
  input  logic                 deadtime_wen,
  input  logic [NUM_CH-1:0]    polarity_in,
  input  logic                 polarity_wen,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic [NUM_CH-1:0]    pwm_out_n,
  output logic                 period_irq,
  output logic [CNT_WIDTH-1:0] count_out
);

  logic [CNT_WIDTH-1:0] period_sh, period_act, period_nx, period_m1, cnt;
  logic [CNT_WIDTH-1:0] duty_sh  [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_act [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_nx  [NUM_CH];
  logic [DT_WIDTH-1:0]  dt_sh, dt_act, dt_nx;
  logic [DT_WIDTH-1:0]  dt_cnt  [NUM_CH];
  logic [DT_WIDTH-1:0]  dt_load [NUM_CH];
  logic [NUM_CH-1:0]    pol, pol_nx, raw, raw_q, leg_a, leg_b;
  logic                 align_act, dir_down, period_zero, boundary, load_act;

  // Shadow next-values; a write in the load cycle bypasses straight to the active set.
  always_comb begin
    period_nx = period_wen   ? period_in   : period_sh;
    dt_nx     = deadtime_wen ? deadtime_in : dt_sh;
    pol_nx    = polarity_wen ? polarity_in : pol;
    for (int i = 0; i < NUM_CH; i++) begin
      duty_nx[i] = (duty_wen && (duty_sel == SEL_W'(i))) ? duty_in : duty_sh[i];
    end
  end

  assign period_zero = (period_act == '0);
  assign period_m1   = period_act - CNT_WIDTH'(1);
  assign boundary    = enable && !period_zero &&
                       (align_act ? (dir_down && (cnt == '0)) : (cnt == period_m1));
  assign load_act    = !enable || period_zero || boundary;
  assign count_out   = cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      period_sh  <= '0;
      period_act <= '0;
      dt_sh      <= '0;
      dt_act     <= '0;
      pol        <= '0;
      align_act  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      period_sh <= period_nx;
      dt_sh     <= dt_nx;
      pol       <= pol_nx;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i] <= duty_nx[i];
      end
      if (load_act) begin
        period_act <= period_nx;
        dt_act     <= dt_nx;
        for (int i = 0; i < NUM_CH; i++) begin
          duty_act[i] <= duty_nx[i];
        end
      end
      if (!enable) begin
        align_act <= align;
      end
    end
  end

  // Timebase: centre mode holds each endpoint for two cycles while the direction flips.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (!enable || period_zero) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (!align_act) begin
      cnt <= (cnt == period_m1) ? '0 : cnt + CNT_WIDTH'(1);
    end else if (!dir_down) begin
      if (cnt == period_m1) begin
        dir_down <= 1'b1;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end else begin
      if (cnt == '0) begin
        dir_down <= 1'b0;
      end else begin
        cnt <= cnt - CNT_WIDTH'(1);
      end
    end
  end

  // Legs are gated on the next dead-time value so the low gap is exactly dt_act cycles.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i]     = !period_zero && (cnt < duty_act[i]);
      dt_load[i] = '0;
      leg_a[i]   = 1'b0;
      leg_b[i]   = 1'b0;
      if (enable) begin
        if (raw[i] != raw_q[i]) begin
          dt_load[i] = dt_act;
        end else if (dt_cnt[i] != '0) begin
          dt_load[i] = dt_cnt[i] - DT_WIDTH'(1);
        end
        if (dt_load[i] == '0) begin
          leg_a[i] = raw[i];
          leg_b[i] = !raw[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      raw_q      <= '0;
      pwm_out    <= '0;
      pwm_out_n  <= '0;
      period_irq <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        dt_cnt[i] <= '0;
      end
    end else begin
      raw_q      <= enable ? raw : '0;
      pwm_out    <= leg_a ^ pol_nx;
      pwm_out_n  <= leg_b ^ pol_nx;
      period_irq <= boundary;
      for (int i = 0; i < NUM_CH; i++) begin
        dt_cnt[i] <= dt_load[i];
      end
    end
  end

endmodule
